// File: rtl/counter_pkg.sv
// Shared counter definitions: saturation-mode encodings and the per-edge
// operation decode that gives clear > load > step > hold.
package counter_pkg;

  localparam int unsigned WRAP = 0;
  localparam int unsigned SAT  = 1;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_STEP,
    OP_LOAD,
    OP_CLR
  } cnt_op_e;

  function automatic cnt_op_e decode_op(input logic clr, input logic load, input logic ce);
    if (clr)       return OP_CLR;
    else if (load) return OP_LOAD;
    else if (ce)   return OP_STEP;
    return OP_HOLD;
  endfunction

endpackage

// File: rtl/bin2gray.sv
// Parametrised binary-to-Gray converter, purely combinational, shared with
// FIFO pointer logic.
module bin2gray #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray_updown_counter.sv
// Up/down counter with registered binary and Gray outputs that update together,
// plus a one-cycle wrap/saturation pulse.
module gray_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned       WIDTH       = 4,
  parameter int unsigned       SATURATE    = WRAP,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ce,
  input  logic             i_up,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_bin_cnt_out,
  output logic [WIDTH-1:0] o_gray_cnt_out,
  output logic             o_wrap
);

  localparam logic [WIDTH-1:0] MAX_CNT   = '1;
  localparam logic [WIDTH-1:0] RST_GRAY  = RESET_VALUE ^ (RESET_VALUE >> 1);

  logic [WIDTH-1:0] bin_q,  bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch can be inferred.
    bin_d  = bin_q;
    wrap_d = 1'b0;
    unique case (decode_op(i_clr, i_load, i_ce))
      OP_CLR:  bin_d = '0;
      OP_LOAD: bin_d = i_load_val;
      OP_STEP: begin
        if (i_up) begin
          if (bin_q == MAX_CNT) begin
            wrap_d = 1'b1;
            if (SATURATE == WRAP) bin_d = '0;
          end else begin
            bin_d = bin_q + WIDTH'(1);
          end
        end else begin
          if (bin_q == '0) begin
            wrap_d = 1'b1;
            if (SATURATE == WRAP) bin_d = MAX_CNT;
          end else begin
            bin_d = bin_q - WIDTH'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Gray is derived from the next binary value so both registers load at one edge.
  bin2gray #(.WIDTH(WIDTH)) u_bin2gray (
    .bin_i  (bin_d),
    .gray_o (gray_d)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bin_q  <= RESET_VALUE;
      gray_q <= RST_GRAY;
      wrap_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so all three registers see pre-edge values.
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign o_bin_cnt_out  = bin_q;
  assign o_gray_cnt_out = gray_q;
  assign o_wrap         = wrap_q;

endmodule

// File: tb/tb_gray_updown_counter.sv
// Scoreboard bench for gray_updown_counter: directed wrap/saturate/priority/reset
// scenarios on 4-bit instances and a randomised run on a 7-bit instance.
module tb_gray_updown_counter;
  import counter_pkg::*;

  typedef struct { logic ce; logic up; logic clr; logic load; logic [6:0] lv; } stim_t;
  typedef struct { logic [31:0] bin; logic [31:0] gray; logic wrap; } exp_t;

  stim_t st_q[$];
  exp_t  sb_q[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    sel         = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b0, up = 1'b0, clr = 1'b0, load = 1'b0;
  logic [6:0] lv7 = '0;
  logic [3:0] lv4;
  assign lv4 = lv7[3:0];

  logic [3:0] w_bin, w_gray, s_bin, s_gray, r_bin, r_gray;
  logic [6:0] x_bin, x_gray;
  logic       w_wrap, s_wrap, r_wrap, x_wrap;

  always #5 clk = ~clk;

  gray_updown_counter #(.WIDTH(4), .SATURATE(WRAP), .RESET_VALUE(4'd0)) u_wrap (
    .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_up(up), .i_clr(clr), .i_load(load),
    .i_load_val(lv4), .o_bin_cnt_out(w_bin), .o_gray_cnt_out(w_gray), .o_wrap(w_wrap));

  gray_updown_counter #(.WIDTH(4), .SATURATE(SAT), .RESET_VALUE(4'd0)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_up(up), .i_clr(clr), .i_load(load),
    .i_load_val(lv4), .o_bin_cnt_out(s_bin), .o_gray_cnt_out(s_gray), .o_wrap(s_wrap));

  gray_updown_counter #(.WIDTH(4), .SATURATE(WRAP), .RESET_VALUE(4'd5)) u_rv5 (
    .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_up(up), .i_clr(clr), .i_load(load),
    .i_load_val(lv4), .o_bin_cnt_out(r_bin), .o_gray_cnt_out(r_gray), .o_wrap(r_wrap));

  gray_updown_counter #(.WIDTH(7), .SATURATE(WRAP), .RESET_VALUE(7'd0)) u_rand (
    .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_up(up), .i_clr(clr), .i_load(load),
    .i_load_val(lv7), .o_bin_cnt_out(x_bin), .o_gray_cnt_out(x_gray), .o_wrap(x_wrap));

  logic [31:0] obs_bin, obs_gray;
  logic        obs_wrap;
  always_comb begin
    obs_bin = {25'd0, x_bin}; obs_gray = {25'd0, x_gray}; obs_wrap = x_wrap;
    case (sel)
      0: begin obs_bin = {28'd0, w_bin}; obs_gray = {28'd0, w_gray}; obs_wrap = w_wrap; end
      1: begin obs_bin = {28'd0, s_bin}; obs_gray = {28'd0, s_gray}; obs_wrap = s_wrap; end
      2: begin obs_bin = {28'd0, r_bin}; obs_gray = {28'd0, r_gray}; obs_wrap = r_wrap; end
      default: ;
    endcase
  end

  function automatic logic [31:0] gray_of(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic push(input logic c, input logic u, input logic cl, input logic ld,
                      input logic [6:0] v, input logic [31:0] eb, input logic [31:0] eg,
                      input logic ew);
    stim_t s;
    exp_t  e;
    s.ce = c; s.up = u; s.clr = cl; s.load = ld; s.lv = v;
    e.bin = eb; e.gray = eg; e.wrap = ew;
    st_q.push_back(s);
    sb_q.push_back(e);
  endtask

  task automatic drive(input stim_t s);
    ce = s.ce; up = s.up; clr = s.clr; load = s.load; lv7 = s.lv;
  endtask

  task automatic do_reset();
    rst = 1'b1; ce = 1'b0; up = 1'b0; clr = 1'b0; load = 1'b0; lv7 = '0;
    #4;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk); #1;
    vectors++; if (w_bin  !== 4'd0)    begin miscompares++; $display("FAIL reset w_bin: got %0d want 0", w_bin); end
    vectors++; if (w_gray !== 4'd0)    begin miscompares++; $display("FAIL reset w_gray: got %b want 0000", w_gray); end
    vectors++; if (w_wrap !== 1'b0)    begin miscompares++; $display("FAIL reset w_wrap: got %b want 0", w_wrap); end
    vectors++; if (s_bin  !== 4'd0)    begin miscompares++; $display("FAIL reset s_bin: got %0d want 0", s_bin); end
    vectors++; if (r_bin  !== 4'd5)    begin miscompares++; $display("FAIL reset r_bin: got %0d want 5", r_bin); end
    vectors++; if (r_gray !== 4'b0111) begin miscompares++; $display("FAIL reset r_gray: got %b want 0111", r_gray); end
    vectors++; if (r_wrap !== 1'b0)    begin miscompares++; $display("FAIL reset r_wrap: got %b want 0", r_wrap); end
    vectors++; if (x_bin  !== 7'd0)    begin miscompares++; $display("FAIL reset x_bin: got %0d want 0", x_bin); end
    vectors++; if (x_gray !== 7'd0)    begin miscompares++; $display("FAIL reset x_gray: got %b want 0", x_gray); end
    rst = 1'b0;
  endtask

  task automatic test_count_up();
    exp_t e;
    logic [31:0] prev_g = 0;
    sel = 0;
    do_reset();
    for (int i = 0; i < 17; i++)
      push(1, 1, 0, 0, 0, (i + 1) % 16, gray_of((i + 1) % 16), i == 15);
    while (st_q.size() > 0) begin
      drive(st_q.pop_front());
      @(posedge clk); #1;
      e = sb_q.pop_front();
      vectors++; if (obs_bin  !== e.bin)  begin miscompares++; $display("FAIL count_up bin: got %0d want %0d", obs_bin, e.bin); end
      vectors++; if (obs_gray !== e.gray) begin miscompares++; $display("FAIL count_up gray: got %b want %b", obs_gray[3:0], e.gray[3:0]); end
      vectors++; if (obs_wrap !== e.wrap) begin miscompares++; $display("FAIL count_up wrap: got %b want %b", obs_wrap, e.wrap); end
      vectors++; if ($countones(obs_gray ^ prev_g) != 1) begin miscompares++; $display("FAIL count_up hamming: got %b after %b", obs_gray[3:0], prev_g[3:0]); end
      prev_g = e.gray;
    end
  endtask

  task automatic test_wrap_down();
    exp_t e;
    sel = 0;
    push(0, 0, 0, 1, 0, 0,  0,       0);
    push(1, 0, 0, 0, 0, 15, 4'b1000, 1);
    push(1, 0, 0, 0, 0, 14, 4'b1001, 0);
    push(1, 1, 0, 0, 0, 15, 4'b1000, 0);
    push(1, 1, 0, 0, 0, 0,  0,       1);
    push(1, 0, 0, 0, 0, 15, 4'b1000, 1);
    push(1, 1, 0, 0, 0, 0,  0,       1);
    push(1, 1, 0, 0, 0, 1,  4'b0001, 0);
    push(1, 0, 0, 0, 0, 0,  0,       0);
    while (st_q.size() > 0) begin
      drive(st_q.pop_front());
      @(posedge clk); #1;
      e = sb_q.pop_front();
      vectors++; if (obs_bin  !== e.bin)  begin miscompares++; $display("FAIL wrap_down bin: got %0d want %0d", obs_bin, e.bin); end
      vectors++; if (obs_gray !== e.gray) begin miscompares++; $display("FAIL wrap_down gray: got %b want %b", obs_gray[3:0], e.gray[3:0]); end
      vectors++; if (obs_wrap !== e.wrap) begin miscompares++; $display("FAIL wrap_down wrap: got %b want %b", obs_wrap, e.wrap); end
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    sel = 1;
    push(0, 0, 0, 1, 14, 14, 4'b1001, 0);
    push(1, 1, 0, 0, 0,  15, 4'b1000, 0);
    push(1, 1, 0, 0, 0,  15, 4'b1000, 1);
    push(1, 1, 0, 0, 0,  15, 4'b1000, 1);
    push(1, 1, 0, 0, 0,  15, 4'b1000, 1);
    push(0, 1, 0, 0, 0,  15, 4'b1000, 0);
    push(0, 0, 0, 1, 1,  1,  4'b0001, 0);
    push(1, 0, 0, 0, 0,  0,  0,       0);
    push(1, 0, 0, 0, 0,  0,  0,       1);
    push(1, 0, 0, 0, 0,  0,  0,       1);
    push(1, 1, 0, 0, 0,  1,  4'b0001, 0);
    while (st_q.size() > 0) begin
      drive(st_q.pop_front());
      @(posedge clk); #1;
      e = sb_q.pop_front();
      vectors++; if (obs_bin  !== e.bin)  begin miscompares++; $display("FAIL saturate bin: got %0d want %0d", obs_bin, e.bin); end
      vectors++; if (obs_gray !== e.gray) begin miscompares++; $display("FAIL saturate gray: got %b want %b", obs_gray[3:0], e.gray[3:0]); end
      vectors++; if (obs_wrap !== e.wrap) begin miscompares++; $display("FAIL saturate wrap: got %b want %b", obs_wrap, e.wrap); end
    end
  endtask

  task automatic test_priority();
    exp_t e;
    sel = 0;
    push(1, 1, 1, 1, 9, 0,  0,       0);
    push(0, 0, 0, 1, 9, 9,  4'b1101, 0);
    push(1, 1, 0, 1, 3, 3,  4'b0010, 0);
    push(1, 0, 1, 0, 3, 0,  0,       0);
    push(0, 0, 0, 0, 3, 0,  0,       0);
    push(1, 0, 0, 0, 0, 15, 4'b1000, 1);
    push(0, 1, 0, 0, 0, 15, 4'b1000, 0);
    while (st_q.size() > 0) begin
      drive(st_q.pop_front());
      @(posedge clk); #1;
      e = sb_q.pop_front();
      vectors++; if (obs_bin  !== e.bin)  begin miscompares++; $display("FAIL priority bin: got %0d want %0d", obs_bin, e.bin); end
      vectors++; if (obs_gray !== e.gray) begin miscompares++; $display("FAIL priority gray: got %b want %b", obs_gray[3:0], e.gray[3:0]); end
      vectors++; if (obs_wrap !== e.wrap) begin miscompares++; $display("FAIL priority wrap: got %b want %b", obs_wrap, e.wrap); end
    end
  endtask

  task automatic test_reset_value();
    exp_t e;
    sel = 2;
    do_reset();
    push(1, 1, 0, 0, 0, 6, 4'b0101, 0);
    push(1, 1, 0, 0, 0, 7, 4'b0100, 0);
    push(1, 1, 0, 0, 0, 8, 4'b1100, 0);
    while (st_q.size() > 0) begin
      drive(st_q.pop_front());
      @(posedge clk); #1;
      e = sb_q.pop_front();
      vectors++; if (obs_bin  !== e.bin)  begin miscompares++; $display("FAIL reset_value bin: got %0d want %0d", obs_bin, e.bin); end
      vectors++; if (obs_gray !== e.gray) begin miscompares++; $display("FAIL reset_value gray: got %b want %b", obs_gray[3:0], e.gray[3:0]); end
    end
    // Reset asserted between edges with a step pending must act at once.
    #3 rst = 1'b1;
    #1;
    vectors++; if (r_bin  !== 4'd5)    begin miscompares++; $display("FAIL async_reset bin: got %0d want 5", r_bin); end
    vectors++; if (r_gray !== 4'b0111) begin miscompares++; $display("FAIL async_reset gray: got %b want 0111", r_gray); end
    vectors++; if (r_wrap !== 1'b0)    begin miscompares++; $display("FAIL async_reset wrap: got %b want 0", r_wrap); end
    @(posedge clk); #1;
    vectors++; if (r_bin  !== 4'd5)    begin miscompares++; $display("FAIL reset_hold bin: got %0d want 5", r_bin); end
    rst = 1'b0;
    push(1, 1, 0, 0, 0, 6, 4'b0101, 0);
    while (st_q.size() > 0) begin
      drive(st_q.pop_front());
      @(posedge clk); #1;
      e = sb_q.pop_front();
      vectors++; if (obs_bin  !== e.bin)  begin miscompares++; $display("FAIL post_reset bin: got %0d want %0d", obs_bin, e.bin); end
      vectors++; if (obs_gray !== e.gray) begin miscompares++; $display("FAIL post_reset gray: got %b want %b", obs_gray[3:0], e.gray[3:0]); end
      vectors++; if (obs_wrap !== e.wrap) begin miscompares++; $display("FAIL post_reset wrap: got %b want %b", obs_wrap, e.wrap); end
    end
  endtask

  task automatic test_random();
    exp_t       e;
    stim_t      s;
    logic [6:0] cur = '0, nxt;
    logic       w, stepped;
    sel = 3;
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      s.ce = ($urandom_range(3) != 0); s.up = 1'($urandom_range(1));
      s.clr = ($urandom_range(31) == 0); s.load = ($urandom_range(15) == 0);
      s.lv = 7'($urandom_range(127));
      w = 1'b0; stepped = 1'b0;
      if (s.clr)       nxt = '0;
      else if (s.load) nxt = s.lv;
      else if (s.ce) begin
        stepped = 1'b1;
        if (s.up) begin w = (cur == 7'd127); nxt = cur + 7'd1; end
        else      begin w = (cur == 7'd0);   nxt = cur - 7'd1; end
      end else nxt = cur;
      e.bin = {25'd0, nxt}; e.gray = gray_of({25'd0, nxt}); e.wrap = w;
      sb_q.push_back(e);
      drive(s);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      vectors++; if (obs_bin  !== e.bin)  begin miscompares++; $display("FAIL random bin @%0d: got %0d want %0d", i, obs_bin, e.bin); end
      vectors++; if (obs_gray !== e.gray) begin miscompares++; $display("FAIL random gray @%0d: got %b want %b", i, obs_gray[6:0], e.gray[6:0]); end
      vectors++; if (obs_wrap !== e.wrap) begin miscompares++; $display("FAIL random wrap @%0d: got %b want %b", i, obs_wrap, e.wrap); end
      if (stepped) begin
        vectors++;
        if ($countones(obs_gray ^ gray_of({25'd0, cur})) != 1) begin
          miscompares++; $display("FAIL random hamming @%0d: got %b from %b", i, obs_gray[6:0], gray_of({25'd0, cur}));
        end
      end
      cur = nxt;
    end
  endtask

  initial begin
    test_reset();
    test_reset_value();
    test_count_up();
    test_wrap_down();
    test_saturate();
    test_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gray_updown_counter.md
GRAY_UPDOWN_COUNTER -- requirements
Module: gray_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits; legal range 2..32.
REQ-002 Parameter SATURATE, default 0: 0 = wrap at limits; 1 = hold at limits.
REQ-003 Parameter RESET_VALUE, default 0: binary count after reset; WIDTH bits.
REQ-004 i_clk  in  1  single clock; all state is updated on the rising edge.
REQ-005 i_rst  in  1  asynchronous, active-high reset.
REQ-006 i_ce  in  1  count enable; one step per enabled cycle.
REQ-007 i_up  in  1  direction: 1 = increment, 0 = decrement; sampled only when a step occurs.
REQ-008 i_clr  in  1  synchronous clear to zero.
REQ-009 i_load  in  1  synchronous load of i_load_val.
REQ-010 i_load_val  in  WIDTH  binary value to load.
REQ-011 o_bin_cnt_out  out  WIDTH  registered binary count.
REQ-012 o_gray_cnt_out  out  WIDTH  registered Gray code of o_bin_cnt_out; coherent in the same cycle.
REQ-013 o_wrap  out  1  registered one-cycle pulse on a wrap event or a saturation hit.

Function
REQ-014 Priority at each rising edge shall be: i_clr, then i_load, then i_ce step, then hold.
REQ-015 i_clr and i_load shall act regardless of i_ce.
REQ-016 i_clr=1 shall set the binary count to 0, the Gray count to 0, and o_wrap to 0 at that edge.
REQ-017 i_load=1 (i_clr=0) shall set the binary count to i_load_val, the Gray count to gray(i_load_val), and o_wrap to 0 at that edge.
REQ-018 A step shall change the count by +1 (i_up=1) or -1 (i_up=0), modulo 2^WIDTH when SATURATE=0.
REQ-019 Step latency shall be one cycle: both outputs show the new value the cycle after the i_ce edge; there shall be no extra pipeline stage.
REQ-020 o_gray_cnt_out shall equal b ^ (b >> 1), where b is the next binary value, registered at the same edge as o_bin_cnt_out.
REQ-021 With SATURATE=0: stepping up from 2^WIDTH-1 shall give 0, stepping down from 0 shall give 2^WIDTH-1, and o_wrap=1 for the following cycle.
REQ-022 With SATURATE=1: a step up at 2^WIDTH-1 or a step down at 0 shall leave the count unchanged and set o_wrap=1 for one cycle.
REQ-023 With SATURATE=1, repeated saturated steps shall pulse o_wrap on every such edge.
REQ-024 o_wrap shall be 0 on every edge without a wrap or saturation event, including hold cycles.
REQ-025 Consecutive stepped values of o_gray_cnt_out shall differ in exactly one bit, including across a wrap.
REQ-026 Direction reversal on consecutive cycles shall need no extra cycle and shall generate no spurious o_wrap.

Reset
REQ-027 While i_rst=1: o_bin_cnt_out=RESET_VALUE, o_gray_cnt_out=gray(RESET_VALUE), o_wrap=0, independent of i_clk.
REQ-028 Reset asserted mid-count shall take effect immediately and discard any pending step, load or clear.
REQ-029 The first edge after deassertion shall obey REQ-014 normally, with no dead cycle.

Structure
REQ-030 The SATURATE mode encodings (WRAP=0, SAT=1) shall be constants in the shared counter package, used by this block and future counters.
REQ-031 The binary-to-Gray conversion shall be a separate parametrised combinational sub-module, bin2gray (WIDTH), reusable by FIFO pointer logic.
REQ-032 All outputs shall be driven directly from flops; there shall be no combinational path from inputs to outputs.

Verification
REQ-033 WIDTH=4, SATURATE=0, i_ce=1, i_up=1 for 17 cycles from reset -> bin 0,1,...,15,0,1; gray 0000,0001,0011,...,1000,0000; o_wrap=1 only on the cycle bin returns to 0.
REQ-034 WIDTH=4, SATURATE=0, load 0, then i_up=0 for 1 step -> bin=15, gray=1000, o_wrap pulse; next step -> bin=14, o_wrap=0.
REQ-035 WIDTH=4, SATURATE=1, load 14, i_up=1 for 4 steps -> bin 15,15,15,15; o_wrap=1 on steps 2, 3 and 4.
REQ-036 i_clr=1, i_load=1 (i_load_val=9), i_ce=1 in the same cycle -> bin=0, gray=0, o_wrap=0; next cycle with i_load only -> bin=9, gray=1101.
REQ-037 RESET_VALUE=5; count to 8, then assert i_rst asynchronously between edges -> outputs go to bin=5, gray=0111 before the next edge; after deassertion with i_ce=1 -> bin=6.
REQ-038 Random i_ce/i_up/i_load/i_clr for 10k cycles, WIDTH=7 -> a scoreboard matches bin, gray=bin^(bin>>1), o_wrap; the Gray Hamming distance is 1 on every step.
